dma_copy: RTL
=============

DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8: width of the configuration-window byte address.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of the word-count register.
REQ-003 SHALL have clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have rstn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have wr / waddr / wdata, input, 1 / ADDRESS_WIDTH / 32: configuration write port, single-cycle strobe.
REQ-006 SHALL have rd / raddr, input, 1 / ADDRESS_WIDTH: configuration read request.
REQ-007 SHALL have rdata, output, 32: configuration read data, valid exactly one cycle after rd.
REQ-008 SHALL have m_grant, input, 1: data bus free; the master issues no request while low.
REQ-009 SHALL have m_rd / m_raddr, output, 1 / 32: master read request; the slave returns m_rdata one cycle later.
REQ-010 SHALL have m_rdata, input, 32: master read data.
REQ-011 SHALL have m_wr / m_waddr / m_wdata / m_wstrb, output, 1 / 32 / 32 / 4: master write, single-cycle strobe.
REQ-012 SHALL have irq, output, 1: level interrupt equal to STATUS.done AND CTRL.irq_en.

Function
REQ-013 SHALL decode registers at waddr/raddr[7:0]: 0x00 SRC, 0x04 DST, 0x08 LEN (LEN_WIDTH bits, words), 0x0C CTRL, 0x10 STATUS, 0x14 REMAIN (read-only); unmapped reads return 0 and unmapped writes are ignored.
REQ-014 SHALL force SRC[1:0] and DST[1:0] to 0 on write.
REQ-015 SHALL define CTRL as: bit0 start (write-1 pulse, reads 0), bit1 irq_en (RW), bit2 abort (write-1 pulse, reads 0).
REQ-016 SHALL define STATUS as: bit0 busy (RO), bit1 done (sticky, write-1-to-clear), bit2 aborted (sticky, write-1-to-clear).
REQ-017 SHALL use FSM states IDLE, READ, WAIT, WRITE, DONE.
REQ-018 SHALL, in IDLE on start with LEN!=0, load working src/dst/remain from SRC/DST/LEN, clear done/aborted, and enter READ.
REQ-019 SHALL, on start with LEN==0, set done in the next cycle with no bus activity.
REQ-020 SHALL, in READ, drive m_rd=1 and m_raddr=src combinationally when m_grant=1, then go to WAIT; with m_grant=0 it holds with m_rd=0.
REQ-021 SHALL, in WAIT, capture m_rdata unconditionally regardless of m_grant and go to WRITE.
REQ-022 SHALL, in WRITE with m_grant=1, drive m_wr=1, m_waddr=dst, m_wdata=captured word, m_wstrb=4'hF; src+=4, dst+=4, remain-=1; go to DONE if remain was 1, else READ.
REQ-023 SHALL wrap address increments modulo 2^32.
REQ-024 SHALL, in DONE, set done and return to IDLE one cycle later; busy=1 in all states except IDLE.
REQ-025 SHALL achieve 3 cycles per word when m_grant is held high.
REQ-026 SHALL ignore start and writes to SRC/DST/LEN while busy; CTRL.irq_en remains writable.
REQ-027 SHALL, on abort while busy, enter IDLE next cycle, deassert m_rd/m_wr in that cycle, set aborted, leave done clear, and freeze REMAIN; abort in IDLE has no effect.
REQ-028 SHALL give abort priority over start when both are written in the same cycle.
REQ-029 SHALL give a done-set priority over a simultaneous W1C clear of done.

Reset
REQ-030 SHALL, on rstn low, asynchronously force FSM=IDLE and SRC/DST/LEN/REMAIN/CTRL/STATUS/rdata=0.
REQ-031 SHALL hold m_rd=m_wr=0, m_raddr=m_waddr=m_wdata=0, m_wstrb=0 and irq=0 while in reset.
REQ-032 SHALL abandon any in-flight transfer on reset mid-operation, with no further bus requests issued.

Structure
REQ-033 SHALL place register offsets, CTRL/STATUS bit positions and the FSM state encoding in a shared package, dma_pkg.
REQ-034 SHALL be implemented as one sub-module, dma_regs (configuration decode and read mux), plus the FSM/datapath in dma_copy.

Verification
REQ-035 SHALL cover: SRC=0x0100_0000, DST=0x0100_0100, LEN=4, start, grant=1 -> 4 writes of mirrored data to 0x0100_0100..0x0100_010C, done=1 after 12 cycles plus 1 cycle for DONE.
REQ-036 SHALL cover: LEN=0, start -> no m_rd/m_wr, done=1 the next cycle, irq=1 if irq_en=1.
REQ-037 SHALL cover: grant toggled 0/1 every 2 cycles during LEN=3 -> no request while grant=0, all data correct.
REQ-038 SHALL cover: abort after the second write of LEN=8 -> aborted=1, done=0, REMAIN=6, bus idle thereafter.
REQ-039 SHALL cover: SRC=0xFFFF_FFFC, LEN=2 -> second read at 0x0000_0000.
REQ-040 SHALL cover: rstn pulsed low in the WAIT state -> all outputs 0 immediately, FSM in IDLE, no write issued.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared register map, control/status bit positions and FSM encoding for dma_copy
package dma_pkg;

    localparam logic [7:0] REG_SRC    = 8'h00;
    localparam logic [7:0] REG_DST    = 8'h04;
    localparam logic [7:0] REG_LEN    = 8'h08;
    localparam logic [7:0] REG_CTRL   = 8'h0C;
    localparam logic [7:0] REG_STATUS = 8'h10;
    localparam logic [7:0] REG_REMAIN = 8'h14;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_ABORT   = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } dma_state_t;

endpackage

// File: rtl/dma_if.sv
// rtl/dma_if.sv - word-wide data bus between the copy engine (master) and memory (slave)
interface dma_if;
    logic        m_grant;
    logic        m_rd;
    logic [31:0] m_raddr;
    logic [31:0] m_rdata;
    logic        m_wr;
    logic [31:0] m_waddr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;

    modport master (
        input  m_grant, m_rdata,
        output m_rd, m_raddr, m_wr, m_waddr, m_wdata, m_wstrb
    );

    modport slave (
        output m_grant, m_rdata,
        input  m_rd, m_raddr, m_wr, m_waddr, m_wdata, m_wstrb
    );
endinterface

// File: rtl/dma_regs.sv
// rtl/dma_regs.sv - configuration window: register storage, write decode pulses and registered read mux
module dma_regs
    import dma_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic                     rd,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    input  logic                     busy,
    input  logic                     done,
    input  logic                     aborted,
    input  logic [LEN_WIDTH-1:0]     remain,
    output logic [31:0]              rdata,
    output logic [31:0]              src,
    output logic [31:0]              dst,
    output logic [LEN_WIDTH-1:0]     len,
    output logic                     irq_en,
    output logic                     start,
    output logic                     abort,
    output logic                     clr_done,
    output logic                     clr_aborted
);

    logic [7:0]  wsel;
    logic [7:0]  rsel;
    logic        wr_ctrl;
    logic        wr_status;
    logic [31:0] rd_mux;

    assign wsel        = waddr[7:0];
    assign rsel        = raddr[7:0];
    assign wr_ctrl     = wr && (wsel == REG_CTRL);
    assign wr_status   = wr && (wsel == REG_STATUS);
    assign start       = wr_ctrl && wdata[CTRL_START];
    assign abort       = wr_ctrl && wdata[CTRL_ABORT];
    assign clr_done    = wr_status && wdata[STAT_DONE];
    assign clr_aborted = wr_status && wdata[STAT_ABORTED];

    always_comb begin
        rd_mux = '0;
        case (rsel)
            REG_SRC:    rd_mux = src;
            REG_DST:    rd_mux = dst;
            REG_LEN:    rd_mux[LEN_WIDTH-1:0] = len;
            REG_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
            REG_STATUS: begin
                rd_mux[STAT_BUSY]    = busy;
                rd_mux[STAT_DONE]    = done;
                rd_mux[STAT_ABORTED] = aborted;
            end
            REG_REMAIN: rd_mux[LEN_WIDTH-1:0] = remain;
            default:    rd_mux = '0;
        endcase
    end

    // Transfer parameters are frozen while the engine runs; irq_en stays live.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            irq_en <= 1'b0;
            rdata  <= '0;
        end else begin
            if (wr && !busy) begin
                case (wsel)
                    REG_SRC: src <= {wdata[31:2], 2'b00};
                    REG_DST: dst <= {wdata[31:2], 2'b00};
                    REG_LEN: len <= wdata[LEN_WIDTH-1:0];
                    default: ;
                endcase
            end
            if (wr_ctrl) begin
                irq_en <= wdata[CTRL_IRQ_EN];
            end
            rdata <= rd ? rd_mux : '0;
        end
    end

endmodule

// File: rtl/dma_copy.sv
// rtl/dma_copy.sv - single-channel word copy engine: read one word, write it back, repeat LEN times
module dma_copy
    import dma_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic                     rd,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [31:0]              rdata,
    dma_if.master                    bus,
    output logic                     irq
);

    dma_state_t           state;
    dma_state_t           state_next;
    logic [31:0]          cfg_src;
    logic [31:0]          cfg_dst;
    logic [LEN_WIDTH-1:0] cfg_len;
    logic                 irq_en;
    logic                 start;
    logic                 abort;
    logic                 clr_done;
    logic                 clr_aborted;
    logic [31:0]          src_q;
    logic [31:0]          dst_q;
    logic [LEN_WIDTH-1:0] remain;
    logic [31:0]          data_q;
    logic                 done;
    logic                 aborted;
    logic                 busy;
    logic                 start_accept;
    logic                 load;
    logic                 capture;
    logic                 advance;
    logic                 set_done;
    logic                 set_aborted;

    assign busy         = (state != IDLE);
    assign start_accept = (state == IDLE) && start && !abort;
    assign irq          = done && irq_en;

    dma_regs #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .LEN_WIDTH     (LEN_WIDTH)
    ) u_regs (
        .clk         (clk),
        .rstn        (rstn),
        .wr          (wr),
        .waddr       (waddr),
        .wdata       (wdata),
        .rd          (rd),
        .raddr       (raddr),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .remain      (remain),
        .rdata       (rdata),
        .src         (cfg_src),
        .dst         (cfg_dst),
        .len         (cfg_len),
        .irq_en      (irq_en),
        .start       (start),
        .abort       (abort),
        .clr_done    (clr_done),
        .clr_aborted (clr_aborted)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An abort strobe suppresses this cycle's bus request so nothing escapes after it.
    always_comb begin
        state_next   = state;
        bus.m_rd     = 1'b0;
        bus.m_raddr  = '0;
        bus.m_wr     = 1'b0;
        bus.m_waddr  = '0;
        bus.m_wdata  = '0;
        bus.m_wstrb  = '0;
        load         = 1'b0;
        capture      = 1'b0;
        advance      = 1'b0;
        set_done     = 1'b0;
        set_aborted  = 1'b0;
        if (busy && abort) begin
            state_next  = IDLE;
            set_aborted = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_accept) begin
                        if (cfg_len != '0) begin
                            load       = 1'b1;
                            state_next = READ;
                        end else begin
                            set_done = 1'b1;
                        end
                    end
                end
                READ: begin
                    if (bus.m_grant) begin
                        bus.m_rd    = 1'b1;
                        bus.m_raddr = src_q;
                        state_next  = WAIT;
                    end
                end
                WAIT: begin
                    capture    = 1'b1;
                    state_next = WRITE;
                end
                WRITE: begin
                    if (bus.m_grant) begin
                        bus.m_wr    = 1'b1;
                        bus.m_waddr = dst_q;
                        bus.m_wdata = data_q;
                        bus.m_wstrb = 4'hF;
                        advance     = 1'b1;
                        state_next  = (remain == LEN_WIDTH'(1)) ? DONE : READ;
                    end
                end
                DONE: begin
                    set_done   = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_q   <= '0;
            dst_q   <= '0;
            remain  <= '0;
            data_q  <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            if (load) begin
                src_q  <= cfg_src;
                dst_q  <= cfg_dst;
                remain <= cfg_len;
            end else if (advance) begin
                src_q  <= src_q + 32'd4;
                dst_q  <= dst_q + 32'd4;
                remain <= remain - LEN_WIDTH'(1);
            end
            if (capture) begin
                data_q <= bus.m_rdata;
            end
            // Setting wins over a same-cycle software clear.
            if (set_done) begin
                done <= 1'b1;
            end else if (start_accept || clr_done) begin
                done <= 1'b0;
            end
            if (set_aborted) begin
                aborted <= 1'b1;
            end else if (start_accept || clr_aborted) begin
                aborted <= 1'b0;
            end
        end
    end

endmodule
